branch_target_predictor: RTL
============================

// Module: branch_target_predictor
// PURPOSE
//  Fetch-side partner of the branch controller. Predicts next-PC redirection at fetch
//  using a direct-mapped BTB with 2-bit saturating counters. Trains on the resolved
//  outcome (PCsource, target) that the branch controller produces in execute.
//  Flags mispredictions and supplies the corrected PC to the PC mux.
// PARAMETERS
//  XLEN      32     address/data width
//  IDX_BITS  6      BTB index bits (2**IDX_BITS entries)
//  INIT_CTR  2'b01  counter value loaded at reset (weakly not-taken)
// PORTS
//  clk              in   1     clock, rising edge
//  rst              in   1     asynchronous, active-high reset
//  f_valid          in   1     fetch lookup request
//  f_pc             in   XLEN  fetch PC
//  pred_valid       out  1     prediction valid (registered f_valid)
//  pred_taken       out  1     predict redirect
//  pred_target      out  XLEN  predicted target
//  r_valid          in   1     resolve strobe from execute
//  r_pc             in   XLEN  PC of resolved instruction
//  r_branch         in   1     conditional branch
//  r_jal            in   1     jal
//  r_jalr           in   1     jalr
//  r_taken          in   1     actual outcome (branch controller PCsource)
//  r_target         in   XLEN  actual target
//  r_pred_taken     in   1     prediction carried down the pipe
//  r_pred_target    in   XLEN  predicted target carried down the pipe
//  mispredict       out  1     one-cycle redirect pulse
//  redirect_pc      out  XLEN  corrected PC, valid when mispredict=1
//  perf_branches    out  32    resolved control-flow count (see CONFIGURATION)
//  perf_mispredicts out  32    mispredict count (see CONFIGURATION)
// BEHAVIOUR
//  - Index = pc[IDX_BITS+1:2]; tag = pc[XLEN-1:IDX_BITS+2]. Entry = {valid, jump, tag, target, ctr}.
//  - Lookup: f_valid at edge t -> pred_* registered at t+1. hit = valid & tag match.
//    pred_taken = hit & (jump | ctr[1]); pred_target = entry target (0 on miss).
//    f_valid=0 -> pred_valid=0, pred_taken=0. pred_target holds its last value.
//  - Counter FSM: SNT(0) <-> WNT(1) <-> WT(2) <-> ST(3).
//    taken -> +1, saturates at ST; not-taken -> -1, saturates at SNT.
//  - Update on r_valid & (r_branch|r_jal|r_jalr):
//    hit: ctr steps; target <= r_target if r_taken.
//    miss: allocate; tag/target written, valid=1, ctr = r_taken ? WT : WNT.
//    r_jal|r_jalr: jump=1, ctr=ST, target=r_target.
//  - Update on r_valid with no control flag and a hit at r_pc: entry valid <= 0 (alias kill).
//  - Mispredict, registered, asserted at t+1 for r_valid at t:
//    r_pred_taken != r_taken, or (r_taken & r_pred_target != r_target).
//    redirect_pc = r_taken ? r_target : r_pc+4 (mod 2**XLEN).
//    Non-control instr with r_pred_taken=1 -> mispredict, redirect r_pc+4.
//    r_valid=0 -> mispredict=0. redirect_pc holds its last value.
//  - Same-cycle lookup and update, same index: lookup returns pre-update contents.
//  - Reset (async, any time): all valid=0, jump=0, ctr=INIT_CTR.
//    pred_valid/pred_taken/mispredict=0; pred_target/redirect_pc=0.
//    An in-flight mispredict is dropped.
// CONFIGURATION
//  BTP_PERF_CNT_EN defined: perf_branches counts each r_valid with any control flag.
//    perf_mispredicts counts each mispredict pulse.
//    Both 32-bit, wrap 0xFFFFFFFF->0, async reset to 0.
//  Not defined: ports remain, tied to 0; no counter flops.
// TESTING
//  1 reset, lookup pc=0x100 -> pred_valid=1, pred_taken=0, pred_target=0.
//  2 resolve beq pc=0x100 taken tgt=0x80, pred 0 -> mispredict=1, redirect_pc=0x80.
//    Next lookup 0x100 -> taken, target 0x80.
//  3 same branch not-taken x2 -> ctr WT->WNT->SNT. Lookup pred_taken=0.
//    Third not-taken stays SNT, no mispredict when pred 0.
//  4 jal pc=0x40 tgt=0x200 -> lookup 0x40 taken/0x200.
//    jalr pc=0x40 resolves tgt=0x300 with pred tgt 0x200 -> mispredict, redirect 0x300.
//  5 add at pc=0x40 resolved with r_pred_taken=1 -> mispredict, redirect 0x44. Entry invalid.
//  6 rst pulsed mid-mispredict -> outputs 0 at once. With BTP_PERF_CNT_EN counters=0.
//    Counters match scenario totals.

Source files
------------

// File: rtl/branch_target_predictor.sv
// ---------------------------------------------------------------------------
// branch_target_predictor
//   Fetch-side branch target predictor. A direct-mapped BTB holds, per entry,
//   {valid, jump, tag, target, 2-bit saturating counter}. Fetch looks it up
//   one cycle ahead of the PC mux. The execute stage trains the BTB with the
//   resolved outcome. A mispredicted outcome raises a one-cycle redirect pulse
//   carrying the corrected PC.
//
//   Optional feature macro: BTP_PERF_CNT_EN
//     When it is defined, the block has free-running 32-bit branch and
//     mispredict counters.
//     When it is undefined, the perf ports are tied to 0 and the counter
//     flops are not built.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   f_valid, f_pc       fetch lookup request
//   pred_valid/taken/target   registered lookup result (one cycle later)
//   r_valid, r_pc       resolve strobe and PC of the resolved instruction
//   r_branch/jal/jalr   control-flow class of the resolved instruction
//   r_taken, r_target   actual outcome and target
//   r_pred_taken/target prediction carried down the pipe
//   mispredict, redirect_pc   registered redirect pulse and corrected PC
//   perf_branches, perf_mispredicts   performance counters
// ---------------------------------------------------------------------------
module branch_target_predictor #(
  parameter int         XLEN     = 32,
  parameter int         IDX_BITS = 6,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            f_valid,
  input  logic [XLEN-1:0] f_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            r_valid,
  input  logic [XLEN-1:0] r_pc,
  input  logic            r_branch,
  input  logic            r_jal,
  input  logic            r_jalr,
  input  logic            r_taken,
  input  logic [XLEN-1:0] r_target,
  input  logic            r_pred_taken,
  input  logic [XLEN-1:0] r_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);

  localparam int N     = 1 << IDX_BITS;
  localparam int TAG_W = XLEN - IDX_BITS - 2;

  typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} ctr_e;

  logic             valid_q [N];
  logic             jump_q  [N];
  logic [1:0]       ctr_q   [N];
  logic [TAG_W-1:0] tag_q   [N];
  logic [XLEN-1:0]  tgt_q   [N];

  // Lookup side
  logic [IDX_BITS-1:0] f_idx;
  logic [TAG_W-1:0]    f_tag;
  logic                f_hit;

  assign f_idx = f_pc[IDX_BITS+1:2];
  assign f_tag = f_pc[XLEN-1:IDX_BITS+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  // Resolve side
  logic [IDX_BITS-1:0] r_idx;
  logic [TAG_W-1:0]    r_tag;
  logic                r_hit, r_ctrl, r_jump, eff_taken, mp_next;
  logic [XLEN-1:0]     fix_pc;
  logic [1:0]          ctr_step;

  assign r_idx  = r_pc[IDX_BITS+1:2];
  assign r_tag  = r_pc[XLEN-1:IDX_BITS+2];
  assign r_hit  = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign r_jump = r_jal | r_jalr;
  assign r_ctrl = r_branch | r_jump;

  // A non-control instruction can never really be taken. Treating it as
  // not-taken gives redirect r_pc+4 whenever fetch wrongly predicted it.
  assign eff_taken = r_ctrl & r_taken;
  assign mp_next   = r_valid && ((r_pred_taken != eff_taken) ||
                                 (eff_taken && (r_pred_target != r_target)));
  assign fix_pc    = eff_taken ? r_target : r_pc + XLEN'(4);

  // The low PC bits are always zero for aligned fetch and are ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[1:0], r_pc[1:0]};

  // NOTE: every path gets a default first, so no latch is inferred.
  always_comb begin
    ctr_step = ctr_q[r_idx];
    if (r_taken) begin
      if (ctr_q[r_idx] != ST)  ctr_step = ctr_q[r_idx] + 2'd1;
    end else begin
      if (ctr_q[r_idx] != SNT) ctr_step = ctr_q[r_idx] - 2'd1;
    end
  end

  // BTB control bits: these are reset, because a stale valid bit would give
  // a false hit.
  // NOTE: sequential state uses non-blocking assignments. A lookup in the
  // same cycle as an update therefore sees the pre-update entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        jump_q[i]  <= 1'b0;
        ctr_q[i]   <= INIT_CTR;
      end
    end else if (r_valid) begin
      if (r_jump) begin
        valid_q[r_idx] <= 1'b1;
        jump_q[r_idx]  <= 1'b1;
        ctr_q[r_idx]   <= ST;
      end else if (r_branch) begin
        if (r_hit) begin
          ctr_q[r_idx] <= ctr_step;
        end else begin
          valid_q[r_idx] <= 1'b1;
          jump_q[r_idx]  <= 1'b0;
          ctr_q[r_idx]   <= r_taken ? WT : WNT;
        end
      end else if (r_hit) begin
        // A non-control instruction aliased onto a predicting entry kills it.
        valid_q[r_idx] <= 1'b0;
      end
    end
  end

  // NOTE: the tag and target payload is not reset. It is only observed
  // through a valid hit, and valid is cleared by reset.
  always_ff @(posedge clk) begin
    if (r_valid && r_ctrl) begin
      if (r_jump || !r_hit) begin
        tag_q[r_idx] <= r_tag;
        tgt_q[r_idx] <= r_target;
      end else if (r_taken) begin
        tgt_q[r_idx] <= r_target;
      end
    end
  end

  // Registered prediction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid <= f_valid;
      if (f_valid) begin
        pred_taken  <= f_hit && (jump_q[f_idx] || ctr_q[f_idx][1]);
        pred_target <= f_hit ? tgt_q[f_idx] : '0;
      end else begin
        pred_taken <= 1'b0;
      end
    end
  end

  // Registered redirect. Reset drops any pulse that is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= mp_next;
      if (r_valid) redirect_pc <= fix_pc;
    end
  end

`ifdef BTP_PERF_CNT_EN
  logic [31:0] branches_q, mispredicts_q;

  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      if (r_valid && r_ctrl) branches_q    <= branches_q + 32'd1;
      if (mp_next)           mispredicts_q <= mispredicts_q + 32'd1;
    end
  end

  assign perf_branches    = branches_q;
  assign perf_mispredicts = mispredicts_q;
`else
  assign perf_branches    = 32'd0;
  assign perf_mispredicts = 32'd0;
`endif

endmodule
